// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debouncer bank: settle FSM encoding and counter sizing.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_RISING  = 2'd1,
    ST_HIGH    = 2'd2,
    ST_FALLING = 2'd3
  } deb_state_e;

  // Bits needed to hold values 0..max_count inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-FF synchroniser, 4-state settle FSM, registered level/rise/fall.
// DEBOUNCE_LONG_PRESS_EN adds a saturating hold counter and the long_out pulse.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 5_000_000
`ifdef DEBOUNCE_LONG_PRESS_EN
  , parameter int unsigned LONG_CYCLES = 50_000_000
`endif
) (
  input  logic clk,
  input  logic async_reset,
  input  logic sample_en,
  input  logic signal_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
`ifdef DEBOUNCE_LONG_PRESS_EN
  , output logic long_out
`endif
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  deb_state_e    state_q;
  deb_state_e    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_d;
  logic          rise_d;
  logic          fall_d;

  // Synchroniser runs every clk, independent of the sample tick.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= signal_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q   <= ST_LOW;
      cnt_q     <= '0;
      level_out <= 1'b0;
      rise_out  <= 1'b0;
      fall_out  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_out <= level_d;
      rise_out  <= rise_d;
      fall_out  <= fall_d;
    end
  end

  // Settle FSM; state and counter hold on clks without a sample tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_out;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sample_en) begin
      case (state_q)
        ST_LOW: begin
          if (sync2) begin
            state_d = ST_RISING;
            cnt_d   = CW'(1);
          end else begin
            cnt_d = '0;
          end
        end
        ST_RISING: begin
          if (!sync2) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_HIGH: begin
          if (!sync2) begin
            state_d = ST_FALLING;
            cnt_d   = CW'(1);
          end else begin
            cnt_d = '0;
          end
        end
        ST_FALLING: begin
          if (sync2) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HW = cnt_width(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          long_d;

  // Saturating hold counter; firing only on the step into HOLD_MAX gives one pulse per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!level_out) begin
      hold_d = '0;
    end else if (sample_en && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HW'(1);
      long_d = (hold_q == (HOLD_MAX - HW'(1)));
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      hold_q   <= '0;
      long_out <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      long_out <= long_d;
    end
  end
`endif

endmodule

// File: rtl/debouncer_bank.sv
// N-channel debouncer sharing one sample tick; each channel is an independent debounce_channel.
// Define DEBOUNCE_LONG_PRESS_EN to add the per-channel long_out hold pulse.
module debouncer_bank #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 5_000_000,
  parameter int unsigned LONG_CYCLES   = 50_000_000
) (
  input  logic                clk,
  input  logic                async_reset,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] signal_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_out,
  output logic [CHANNELS-1:0] fall_out
`ifdef DEBOUNCE_LONG_PRESS_EN
  , output logic [CHANNELS-1:0] long_out
`endif
);

  // Reject parameter sets the settle FSM and hold counter cannot honour.
  if ((CHANNELS < 1) || (STABLE_CYCLES < 2) || (LONG_CYCLES < 1)) begin : g_bad_cfg
    $error("debouncer_bank: invalid CHANNELS/STABLE_CYCLES/LONG_CYCLES");
  end

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
`ifdef DEBOUNCE_LONG_PRESS_EN
      , .LONG_CYCLES(LONG_CYCLES)
`endif
    ) u_channel (
      .clk        (clk),
      .async_reset(async_reset),
      .sample_en  (sample_en),
      .signal_in  (signal_in[i]),
      .level_out  (level_out[i]),
      .rise_out   (rise_out[i]),
      .fall_out   (fall_out[i])
`ifdef DEBOUNCE_LONG_PRESS_EN
      , .long_out (long_out[i])
`endif
    );
  end

endmodule

// File: tb/tb_debouncer_bank.sv
// Self-checking bench for debouncer_bank against a sample-history reference model.
module tb_debouncer_bank;

  localparam int unsigned C  = 2;
  localparam int unsigned ST = 4;
  localparam int unsigned LC = 8;

  logic         clk = 1'b0;
  logic         async_reset;
  logic         sample_en;
  logic [C-1:0] signal_in;
  logic [C-1:0] level_out;
  logic [C-1:0] rise_out;
  logic [C-1:0] fall_out;
  logic [C-1:0] long_w;

  always #5 clk = ~clk;

`ifdef DEBOUNCE_LONG_PRESS_EN
  logic [C-1:0] long_out;
  assign long_w = long_out;
`else
  assign long_w = '0;
`endif

  debouncer_bank #(
    .CHANNELS     (C),
    .STABLE_CYCLES(ST),
    .LONG_CYCLES  (LC)
  ) dut (
    .clk        (clk),
    .async_reset(async_reset),
    .sample_en  (sample_en),
    .signal_in  (signal_in),
    .level_out  (level_out),
    .rise_out   (rise_out),
    .fall_out   (fall_out)
`ifdef DEBOUNCE_LONG_PRESS_EN
    , .long_out (long_out)
`endif
  );

  // Reference model: pipeline of the raw input and a history of sampled values per channel.
  logic [C-1:0] m_s1, m_s2;
  logic [C-1:0] exp_level, exp_rise, exp_fall, exp_long;
  bit           hist [C][$];
  int unsigned  hold [C];

  int total = 0;
  int bad   = 0;

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0;
    exp_level = '0; exp_rise = '0; exp_fall = '0; exp_long = '0;
    for (int c = 0; c < int'(C); c++) begin
      hist[c].delete();
      hold[c] = 0;
    end
  endtask

  // One clock: model applies the rules to the pre-edge inputs; returns #1 after the edge.
  task automatic tick();
    logic [C-1:0] in_now;
    logic         en_now;
    logic         old;
    int unsigned  diff;
    in_now = signal_in;
    en_now = sample_en;
    @(posedge clk);
    if (async_reset) begin
      model_clear();
    end else begin
      exp_rise = '0; exp_fall = '0; exp_long = '0;
      if (en_now) begin
        for (int c = 0; c < int'(C); c++) begin
          old = exp_level[c];
`ifdef DEBOUNCE_LONG_PRESS_EN
          if (old) begin
            if (hold[c] < LC) begin
              hold[c]++;
              if (hold[c] == LC) exp_long[c] = 1'b1;
            end
          end else begin
            hold[c] = 0;
          end
`endif
          hist[c].push_back(m_s2[c]);
          if (hist[c].size() > ST) void'(hist[c].pop_front());
          diff = 0;
          for (int k = 0; k < hist[c].size(); k++)
            if (hist[c][k] != old) diff++;
          // Level accepts the opposite value after ST consecutive opposite samples.
          if (diff == ST) begin
            exp_level[c] = ~old;
            if (old) exp_fall[c] = 1'b1;
            else     exp_rise[c] = 1'b1;
            hist[c].delete();
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = in_now;
    end
    #1;
  endtask

  task automatic test_reset();
    async_reset = 1'b1; sample_en = 1'b1; signal_in = '0;
    model_clear();
    repeat (3) tick();
    total++;
    if ({level_out, rise_out, fall_out, long_w} !== '0) begin
      bad++; $display("FAIL reset_hold got=%b exp=0", {level_out, rise_out, fall_out, long_w});
    end
    async_reset = 1'b0;
    signal_in = 2'b10;
    repeat (8) begin
      tick(); total++;
      if ({level_out, rise_out, fall_out, long_w} !== {exp_level, exp_rise, exp_fall, exp_long}) begin
        bad++; $display("FAIL reset_setup got=%b exp=%b", {level_out, rise_out, fall_out, long_w}, {exp_level, exp_rise, exp_fall, exp_long});
      end
    end
    signal_in = 2'b11;
    repeat (3) tick();
    async_reset = 1'b1;
    model_clear();
    #2;
    total++;
    if ({level_out, rise_out, fall_out, long_w} !== '0) begin
      bad++; $display("FAIL reset_async got=%b exp=0", {level_out, rise_out, fall_out, long_w});
    end
    signal_in = '0;
    repeat (2) tick();
    async_reset = 1'b0;
    repeat (3) tick();
    total++;
    if (level_out !== 2'b00) begin
      bad++; $display("FAIL reset_release level got=%b exp=00", level_out);
    end
  endtask

  task automatic test_clean_edge();
    int n;
    sample_en = 1'b1; signal_in = '0;
    repeat (8) tick();
    signal_in[0] = 1'b1;
    n = 0;
    do begin
      tick(); n++; total++;
      if ({level_out, rise_out, fall_out, long_w} !== {exp_level, exp_rise, exp_fall, exp_long}) begin
        bad++; $display("FAIL clean_edge n=%0d got=%b exp=%b", n, {level_out, rise_out, fall_out, long_w}, {exp_level, exp_rise, exp_fall, exp_long});
      end
    end while (!level_out[0] && n < 40);
    total++;
    if (n != int'(ST) + 2) begin
      bad++; $display("FAIL clean_edge_latency got=%0d exp=%0d", n, ST + 2);
    end
    total++;
    if (rise_out !== 2'b01) begin
      bad++; $display("FAIL clean_edge_rise got=%b exp=01", rise_out);
    end
    tick(); total++;
    if (rise_out !== 2'b00 || level_out[0] !== 1'b1) begin
      bad++; $display("FAIL clean_edge_pulse_end rise=%b level=%b exp rise=00 level0=1", rise_out, level_out);
    end
  endtask

  task automatic test_bounce();
    int n;
    sample_en = 1'b1; signal_in = '0;
    repeat (8) tick();
    for (int p = 0; p < 4; p++) begin
      signal_in[0] = (p < 3);
      tick(); total++;
      if ({level_out, rise_out, fall_out, long_w} !== {exp_level, exp_rise, exp_fall, exp_long}) begin
        bad++; $display("FAIL bounce_pre p=%0d got=%b exp=%b", p, {level_out, rise_out, fall_out, long_w}, {exp_level, exp_rise, exp_fall, exp_long});
      end
    end
    signal_in[0] = 1'b1;
    n = 0;
    do begin
      tick(); n++; total++;
      if ({level_out, rise_out, fall_out, long_w} !== {exp_level, exp_rise, exp_fall, exp_long}) begin
        bad++; $display("FAIL bounce n=%0d got=%b exp=%b", n, {level_out, rise_out, fall_out, long_w}, {exp_level, exp_rise, exp_fall, exp_long});
      end
    end while (!level_out[0] && n < 40);
    total++;
    if (n != int'(ST) + 2) begin
      bad++; $display("FAIL bounce_latency got=%0d exp=%0d", n, ST + 2);
    end
  endtask

  task automatic test_sample_en();
    int rise_at;
    sample_en = 1'b1; signal_in = '0;
    repeat (8) tick();
    signal_in[1] = 1'b1;
    rise_at = 0;
    for (int n = 0; n < 30; n++) begin
      sample_en = (n % 3 == 0);
      tick(); total++;
      if ({level_out, rise_out, fall_out, long_w} !== {exp_level, exp_rise, exp_fall, exp_long}) begin
        bad++; $display("FAIL sample_en n=%0d got=%b exp=%b", n, {level_out, rise_out, fall_out, long_w}, {exp_level, exp_rise, exp_fall, exp_long});
      end
      if (rise_out[1] && rise_at == 0) rise_at = n + 1;
    end
    total++;
    if (rise_at != 13) begin
      bad++; $display("FAIL sample_en_latency got=%0d exp=13", rise_at);
    end
    // Start a fall, freeze it mid-count, then let it complete.
    sample_en = 1'b1; signal_in[1] = 1'b0;
    repeat (4) tick();
    sample_en = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick(); total++;
      if ({level_out, rise_out, fall_out, long_w} !== {exp_level, exp_rise, exp_fall, exp_long}) begin
        bad++; $display("FAIL freeze n=%0d got=%b exp=%b", n, {level_out, rise_out, fall_out, long_w}, {exp_level, exp_rise, exp_fall, exp_long});
      end
    end
    sample_en = 1'b1;
    tick(); total++;
    if (level_out[1] !== 1'b1) begin
      bad++; $display("FAIL freeze_resume1 level1 got=%b exp=1", level_out[1]);
    end
    tick(); total++;
    if (level_out[1] !== 1'b0 || fall_out[1] !== 1'b1) begin
      bad++; $display("FAIL freeze_resume2 level1=%b fall1=%b exp 0/1", level_out[1], fall_out[1]);
    end
  endtask

  task automatic test_simultaneous_fall();
    int both, single;
    sample_en = 1'b1; signal_in = 2'b11;
    repeat (8) tick();
    signal_in = 2'b00;
    both = 0; single = 0;
    for (int n = 0; n < 12; n++) begin
      tick(); total++;
      if ({level_out, rise_out, fall_out, long_w} !== {exp_level, exp_rise, exp_fall, exp_long}) begin
        bad++; $display("FAIL simul_fall n=%0d got=%b exp=%b", n, {level_out, rise_out, fall_out, long_w}, {exp_level, exp_rise, exp_fall, exp_long});
      end
      if (fall_out == 2'b11) both++;
      if (fall_out == 2'b01 || fall_out == 2'b10) single++;
    end
    total++;
    if (both != 1 || single != 0 || level_out !== 2'b00) begin
      bad++; $display("FAIL simul_fall_summary both=%0d single=%0d level=%b exp 1/0/00", both, single, level_out);
    end
  endtask

  task automatic test_long_press();
`ifdef DEBOUNCE_LONG_PRESS_EN
    int rise_at, long_at, longs;
    sample_en = 1'b1; signal_in = '0;
    repeat (8) tick();
    for (int press = 0; press < 2; press++) begin
      signal_in[1] = 1'b1;
      rise_at = -1; long_at = -1; longs = 0;
      for (int n = 0; n < 40; n++) begin
        tick(); total++;
        if ({level_out, rise_out, fall_out, long_w} !== {exp_level, exp_rise, exp_fall, exp_long}) begin
          bad++; $display("FAIL long_press n=%0d got=%b exp=%b", n, {level_out, rise_out, fall_out, long_w}, {exp_level, exp_rise, exp_fall, exp_long});
        end
        if (rise_out[1]) rise_at = n;
        if (long_w[1]) begin longs++; long_at = n; end
      end
      total++;
      if (longs != 1 || (long_at - rise_at) != int'(LC)) begin
        bad++; $display("FAIL long_press_count press=%0d pulses=%0d delay=%0d exp 1/%0d", press, longs, long_at - rise_at, LC);
      end
      signal_in[1] = 1'b0;
      repeat (10) tick();
    end
`endif
  endtask

  task automatic test_random();
    int unsigned remain [C];
    for (int c = 0; c < int'(C); c++) remain[c] = 1;
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < int'(C); c++) begin
        remain[c]--;
        if (remain[c] == 0) begin
          signal_in[c] = ~signal_in[c];
          remain[c] = $urandom_range(1, 14);
        end
      end
      sample_en = ($urandom_range(0, 3) != 0);
      tick(); total++;
      if ({level_out, rise_out, fall_out, long_w} !== {exp_level, exp_rise, exp_fall, exp_long}) begin
        bad++; $display("FAIL random n=%0d got=%b exp=%b", n, {level_out, rise_out, fall_out, long_w}, {exp_level, exp_rise, exp_fall, exp_long});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_bounce();
    test_sample_en();
    test_simultaneous_fall();
    test_long_press();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
